mult_div_unit: RTL and testbench

- Iterative integer multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the rs/rt read-port values (readData1/readData2) and computes MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- HI/LO feed the writeData mux for mfhi/mflo; mthi/mtlo load them directly.
- The control unit stalls the pipeline while busy is high.

---
 rtl/mult_div_unit.sv | 173 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Function : Iterative MULT/MULTU/DIV/DIVU into HI/LO. Optional
//            MULTDIV_DIVZERO_FAST_EN short-circuits a zero divisor.
// Revision : 1.0
// ============================================================================
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operandA,
  input  logic [DATA_WIDTH-1:0] operandB,
  input  logic                  hiWrite,
  input  logic                  loWrite,
  output logic                  busy,
  output logic                  done,
  output logic                  divByZero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;     // product high half / remainder
  logic [DATA_WIDTH-1:0]   wrk_q, wrk_d;     // multiplier / dividend -> quotient
  logic [DATA_WIDTH-1:0]   b_q, b_d;         // multiplicand / divisor magnitude
  logic [DATA_WIDTH-1:0]   a_q, a_d;         // raw dividend for the zero-divisor HI
  logic                    isdiv_q, isdiv_d;
  logic                    negq_q, negq_d;
  logic                    negr_q, negr_d;
  logic                    divz_q, divz_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic                    done_q, done_d;
  logic                    dbz_q, dbz_d;

  logic                    sign_a, sign_b;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b;
  logic [DATA_WIDTH:0]     mul_sum, div_sh, div_diff;
  logic [2*DATA_WIDTH-1:0] prod;

  assign sign_a   = ~op[0] & operandA[DATA_WIDTH-1];
  assign sign_b   = ~op[0] & operandB[DATA_WIDTH-1];
  assign mag_a    = sign_a ? -operandA : operandA;
  assign mag_b    = sign_b ? -operandB : operandB;
  assign mul_sum  = {1'b0, acc_q} + {1'b0, (wrk_q[0] ? b_q : '0)};
  assign div_sh   = {acc_q, wrk_q[DATA_WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign prod     = negq_q ? -{acc_q, wrk_q} : {acc_q, wrk_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      wrk_q   <= '0;
      b_q     <= '0;
      a_q     <= '0;
      isdiv_q <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wrk_q   <= wrk_d;
      b_q     <= b_d;
      a_q     <= a_d;
      isdiv_q <= isdiv_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    wrk_d   = wrk_q;
    b_d     = b_q;
    a_d     = a_q;
    isdiv_d = isdiv_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    divz_d  = divz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (hiWrite) hi_d = operandA;
        if (loWrite) lo_d = operandA;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = '0;
          wrk_d   = op[1] ? mag_a : mag_b;
          b_d     = op[1] ? mag_b : mag_a;
          a_d     = operandA;
          isdiv_d = op[1];
          negq_d  = sign_a ^ sign_b;
          negr_d  = sign_a;
          divz_d  = op[1] && (operandB == '0);
`ifdef MULTDIV_DIVZERO_FAST_EN
          if (op[1] && (operandB == '0)) state_d = S_FINISH;
`else
`endif
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (isdiv_q) begin
          // Restoring step: keep the shifted remainder when the trial subtract borrows.
          acc_d = div_diff[DATA_WIDTH] ? div_sh[DATA_WIDTH-1:0] : div_diff[DATA_WIDTH-1:0];
          wrk_d = {wrk_q[DATA_WIDTH-2:0], ~div_diff[DATA_WIDTH]};
        end else begin
          acc_d = mul_sum[DATA_WIDTH:1];
          wrk_d = {mul_sum[0], wrk_q[DATA_WIDTH-1:1]};
        end
        if (cnt_q == CNT_LAST) state_d = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbz_d   = divz_q;
        if (divz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else if (isdiv_q) begin
          lo_d = negq_q ? -wrk_q : wrk_q;
          hi_d = negr_q ? -acc_q : acc_q;
        end else begin
          hi_d = prod[2*DATA_WIDTH-1:DATA_WIDTH];
          lo_d = prod[DATA_WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Function : Directed, scoreboard-checked bench for mult_div_unit.
// Revision : 1.0
// ============================================================================
module tb_mult_div_unit;

`ifdef MULTDIV_DIVZERO_FAST_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, hiWrite, loWrite;
  logic [1:0]  op;
  logic [31:0] operandA, operandB;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  exp_t sb[$];
  int   npass = 0;
  int   nchk  = 0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .hiWrite(hiWrite), .loWrite(loWrite),
    .busy(busy), .done(done), .divByZero(divByZero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Launches one operation, optionally pokes start/loWrite while busy,
  // then pops the scoreboard entry when done appears.
  task automatic run_op(string tag, logic [1:0] o, logic [31:0] a, logic [31:0] b,
                        logic [31:0] ehi, logic [31:0] elo, logic edz, int elat,
                        int restart_at, int lowrite_at);
    exp_t        e;
    int          lat;
    logic        busy_ok, hold_ok;
    logic [31:0] hi0, lo0;
    e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat;
    sb.push_back(e);
    op = o; operandA = a; operandB = b; start = 1'b1;
    tick();
    start = 1'b0;
    hi0 = hi; lo0 = lo;
    lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done && lat < 200) begin
      if (restart_at > 0 && lat == restart_at) start = 1'b1;
      if (lowrite_at > 0 && lat == lowrite_at) begin
        loWrite = 1'b1; operandA = 32'h5A5A5A5A;
      end
      tick();
      lat++;
      start = 1'b0; loWrite = 1'b0;
      if (!done && busy !== 1'b1) busy_ok = 1'b0;
      if (!done && (hi !== hi0 || lo !== lo0)) hold_ok = 1'b0;
    end
    chk({tag, " done_seen"}, {63'd0, done}, 64'd1);
    e = sb.pop_front();
    chk({tag, " hi"}, {32'd0, hi}, {32'd0, e.hi});
    chk({tag, " lo"}, {32'd0, lo}, {32'd0, e.lo});
    chk({tag, " divByZero"}, {63'd0, divByZero}, {63'd0, e.dz});
    chk({tag, " latency"}, 64'(lat), 64'(e.lat));
    chk({tag, " busy_while_running"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, " hilo_stable_while_busy"}, {63'd0, hold_ok}, 64'd1);
    chk({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
    tick();
    chk({tag, " done_one_cycle"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int extra_done;
    reset = 1'b1; start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
    op = 2'b00; operandA = '0; operandB = '0;
    repeat (3) tick();
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst dbz", {63'd0, divByZero}, 64'd0);
    chk("rst hi", {32'd0, hi}, 64'd0);
    chk("rst lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    tick();

    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 0, 0);
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 0, 0);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 0, 0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33, 0, 0);

    run_op("divu_restart", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33, 5, 0);
    extra_done = 0;
    repeat (40) begin
      tick();
      if (done) extra_done++;
    end
    chk("divu_restart no_second_done", 64'(extra_done), 64'd0);

    run_op("divu_zero", 2'b11, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1, DZ_LAT, 0, 0);
    chk("dbz_holds", {63'd0, divByZero}, 64'd1);
    run_op("div_zero_neg", 2'b10, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b1, DZ_LAT, 0, 0);

    hiWrite = 1'b1; operandA = 32'hAAAA5555;
    tick();
    hiWrite = 1'b0; loWrite = 1'b1; operandA = 32'h00001234;
    tick();
    loWrite = 1'b0;
    chk("mthi hi", {32'd0, hi}, {32'd0, 32'hAAAA5555});
    chk("mtlo lo", {32'd0, lo}, {32'd0, 32'h00001234});
    run_op("mult_lowrite_busy", 2'b00, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0, 33, 0, 5);

    op = 2'b10; operandA = 32'd1000; operandB = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort done", {63'd0, done}, 64'd0);
    chk("abort hi", {32'd0, hi}, 64'd0);
    chk("abort lo", {32'd0, lo}, 64'd0);
    run_op("after_abort", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 1'b0, 33, 0, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
`default_nettype wire
